packet_injector: RTL

- Host-to-fabric write path. Software on the Avalon-MM bus pushes 8-bit packet bytes into three per-port FIFOs.
- Each FIFO drains to its switch input port over a valid/ready stream.
- It is the write-side counterpart of the result buffer, which hardware fills and software reads.
- A single address window also exposes FIFO occupancy and status for software polling.

---
 rtl/packet_injector.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/packet_injector.sv
// packet_injector: Avalon-MM writes push bytes into three per-port FIFOs that drain over
// valid/ready streams. Define INJECT_DROP_COUNT_EN to build the per-port drop counters.
module packet_injector #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic              write,
    input  logic              read,
    input  logic [2:0]        address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic              valid1,
    output logic              valid2,
    output logic              valid3,
    input  logic              ready1,
    input  logic              ready2,
    input  logic              ready3
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int N     = 3;

    logic [DATA_W-1:0] mem_q    [N][DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [N];
    logic [PTR_W-1:0]  rd_ptr_d [N];
    logic [PTR_W-1:0]  wr_ptr_q [N];
    logic [PTR_W-1:0]  wr_ptr_d [N];
    logic [OCC_W-1:0]  occ_q    [N];
    logic [OCC_W-1:0]  occ_d    [N];
    logic [DATA_W-1:0] data_q   [N];
    logic [DATA_W-1:0] data_d   [N];
    logic [7:0]        drop_cnt [N];
    logic [N-1:0]      valid_q, valid_d;
    logic [N-1:0]      ready, full, empty, flush, push_req, push, pop;
    logic              enable_q, enable_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              bus_wr, bus_rd;

    assign bus_wr = chipselect && write;
    assign bus_rd = chipselect && read;
    assign ready  = {ready3, ready2, ready1};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        enable_d = enable_q;
        flush    = '0;
        if (bus_wr && address == 3'd3) begin
            enable_d = writedata[7];
            flush    = writedata[2:0];
        end
        for (int i = 0; i < N; i++) begin
            full[i]     = (occ_q[i] == OCC_W'(DEPTH));
            empty[i]    = (occ_q[i] == '0);
            push_req[i] = bus_wr && (address == 3'(i));
            // A full FIFO rejects the push even if it pops this cycle; flush beats both.
            push[i]     = push_req[i] && !full[i] && !flush[i];
            pop[i]      = valid_q[i] && ready[i] && !flush[i];
            rd_ptr_d[i] = '0;
            wr_ptr_d[i] = '0;
            occ_d[i]    = '0;
            if (!flush[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop[i]);
                wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push[i]);
                occ_d[i]    = occ_q[i] + OCC_W'(push[i]) - OCC_W'(pop[i]);
            end
            valid_d[i] = enable_d && (occ_d[i] != '0);
            data_d[i]  = '0;
            if (valid_d[i]) begin
                // The new head may be the byte being written this edge; bypass the array.
                if (push[i] && (rd_ptr_d[i] == wr_ptr_q[i])) begin
                    data_d[i] = writedata;
                end else begin
                    data_d[i] = mem_q[i][rd_ptr_d[i]];
                end
            end
        end
    end

`ifdef INJECT_DROP_COUNT_EN
    logic [7:0] drop_q [N];
    logic [7:0] drop_d [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            drop_d[i] = drop_q[i];
            if (push_req[i] && full[i] && !flush[i] && drop_q[i] != 8'hFF) begin
                drop_d[i] = drop_q[i] + 8'd1;
            end
            drop_cnt[i] = drop_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            drop_q[i] <= reset_n ? drop_d[i] : 8'd0;
        end
    end
`else
    always_comb begin
        for (int i = 0; i < N; i++) begin
            drop_cnt[i] = 8'd0;
        end
    end
`endif

    always_comb begin
        readdata_d = readdata_q;
        if (bus_rd) begin
            case (address)
                3'd0:    readdata_d = DATA_W'(occ_q[0]);
                3'd1:    readdata_d = DATA_W'(occ_q[1]);
                3'd2:    readdata_d = DATA_W'(occ_q[2]);
                3'd3:    readdata_d = DATA_W'({enable_q, full[2], full[1], full[0],
                                               1'b0, empty[2], empty[1], empty[0]});
                3'd4:    readdata_d = DATA_W'(drop_cnt[0]);
                3'd5:    readdata_d = DATA_W'(drop_cnt[1]);
                3'd6:    readdata_d = DATA_W'(drop_cnt[2]);
                default: readdata_d = DATA_W'(8'd252);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable_q   <= 1'b0;
            valid_q    <= '0;
            readdata_q <= '0;
            for (int i = 0; i < N; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
                data_q[i]   <= '0;
            end
        end else begin
            enable_q   <= enable_d;
            valid_q    <= valid_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < N; i++) begin
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
                occ_q[i]    <= occ_d[i];
                data_q[i]   <= data_d[i];
            end
        end
    end

    // NOTE: the storage array is not reset; the pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (reset_n && push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= writedata;
            end
        end
    end

    assign readdata = readdata_q;
    assign valid1   = valid_q[0];
    assign valid2   = valid_q[1];
    assign valid3   = valid_q[2];
    assign data1    = data_q[0];
    assign data2    = data_q[1];
    assign data3    = data_q[2];
endmodule
